mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage; sits directly downstream of the EX/MEM register.
//  - Consumes EX/MEM control (wb, m) plus ALU result/address and store data.
//  - Performs loads and stores over a variable-latency req/ack data-memory port.
//  - Freezes upstream via stall while an access is outstanding.
//  - Drives the registered MEM/WB outputs consumed by the writeback stage.
// PARAMETERS
//  ADDR_W       32  data-memory address width (low ADDR_W bits of resultado)
//  TIMEOUT_CYC  16  max cycles waiting for mem_ack before bus-error abort (>=2)
// PORTS
//  clock               in   1       single clock, rising edge
//  reset_n             in   1       asynchronous reset, active low
//  valid_entrada       in   1       EX/MEM slot holds a real instruction
//  wb_reg_write        in   1       instruction writes the register file
//  wb_mem_to_reg       in   1       writeback data = load data (else ALU result)
//  m_read              in   1       load
//  m_write             in   1       store (m_read & m_write never both set)
//  m_size              in   2       00 byte, 01 half, 10 word, 11 reserved
//  m_unsigned          in   1       zero-extend loads (else sign-extend)
//  resultado           in   32      ALU result / effective address
//  dato_store          in   32      store data, right-justified
//  reg_destino         in   5       destination register
//  stall               out  1       comb; 1 = EX/MEM must hold its contents
//  mem_req             out  1       access request
//  mem_we              out  1       1 = write
//  mem_addr            out  ADDR_W  word-aligned address (low 2 bits forced 0)
//  mem_be              out  4       byte enables, bit i = byte lane i
//  mem_wdata           out  32      lane-replicated store data
//  mem_rdata           in   32      read data, valid when mem_ack=1
//  mem_ack             in   1       access complete
//  valid_salida        out  1       registered MEM/WB valid
//  wb_salida           out  1       registered, qualified reg_write
//  dato_salida         out  32      registered writeback data
//  reg_destino_salida  out  5       registered destination register
//  excepcion           out  1       registered 1-cycle pulse
//  excepcion_causa     out  2       01 misaligned, 10 bus timeout; 00 otherwise
// BEHAVIOUR
//  - Reset (async, reset_n=0): FSM -> IDLE, counter=0, all registered outputs 0.
//    mem_req=0 immediately; in-flight access abandoned, no writeback.
//  - FSM states IDLE, WAIT. mem_* outputs are combinational from EX/MEM inputs
//    (held stable by stall).
//  - Non-memory op or valid_entrada=0: stall=0.
//    MEM/WB loads next edge with dato_salida=resultado. Latency 1 cycle.
//  - Alignment check: half needs addr[0]=0; word needs addr[1:0]=00; m_size=11
//    always faults. Misaligned valid mem op:
//    - no mem_req, stall=0;
//    - next edge: valid_salida=1, wb_salida=0, excepcion=1, causa=01.
//  - Aligned valid mem op in IDLE:
//    - mem_req=1, counter cleared.
//    - mem_ack same cycle: stall=0, complete (zero-wait, latency 1).
//    - Else stall=1, go WAIT.
//  - WAIT: mem_req held with identical addr/be/wdata; counter increments each cycle.
//    - mem_ack: stall=0, complete, -> IDLE.
//    - Counter == TIMEOUT_CYC-1 without ack: stall=0, abort, -> IDLE.
//      Next edge: valid_salida=1, wb_salida=0, excepcion=1, causa=10.
//    - Ack and timeout in the same cycle: ack wins.
//  - Complete:
//    - MEM/WB gets wb_salida=wb_reg_write.
//    - Load: dato_salida = extended lane data.
//    - Store: dato_salida = resultado.
//  - Byte enables: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111.
//  - Store wdata: byte replicated x4; half replicated x2; word as-is.
//  - Load extract: lane selected by a[1:0]; sign from lane MSB unless m_unsigned.
//  - excepcion is high for exactly one cycle per faulting instruction.
//  - wb_salida=0 whenever valid_salida=0.
// STRUCTURE
//  - Package pipeline_pkg: m_size codes, excepcion_causa codes, FSM state encoding.
//  - Sub-module mem_align (combinational): be/wdata generation, load extract/extend.
//  - Top: FSM, timeout counter, MEM/WB output register.
// TESTING
//  1. ALU op, resultado=0x0000_1234, rd=5 -> next cycle dato_salida=0x1234,
//     wb_salida=1, stall never 1.
//  2. lb a=0x103, rdata=0x80xx_xxxx, ack after 3 cycles -> be=1000,
//     stall 3 cycles, dato_salida=0xFFFF_FF80 (lbu: 0x0000_0080).
//  3. sh a=0x102, dato_store=0x0000_BEEF, zero-wait ack -> be=1100,
//     wdata=0xBEEF_BEEF, mem_we=1, no stall.
//  4. lw a=0x101 -> no mem_req, next cycle excepcion=1, causa=01, wb_salida=0.
//  5. lw with ack never asserted, TIMEOUT_CYC=16 -> stall 15 cycles,
//     then excepcion=1, causa=10, mem_req low.
//  6. reset_n low while in WAIT -> mem_req=0 and outputs 0 immediately;
//     late ack ignored after release.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared codes for the MEM pipeline stage
package pipeline_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = a[0];
      SIZE_WORD: is_misaligned = |a;
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - byte-enable/store replication and load lane extract/extend
module mem_align
  import pipeline_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o        = 4'b1111;
    wdata_o     = store_data_i;
    shifted     = rdata_i >> {addr_lo_i, 3'b000};
    load_data_o = rdata_i;
    case (size_i)
      SIZE_BYTE: begin
        be_o        = 4'b0001 << addr_lo_i;
        wdata_o     = {4{store_data_i[7:0]}};
        load_data_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        be_o        = 4'b0011 << addr_lo_i;
        wdata_o     = {2{store_data_i[15:0]}};
        load_data_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: req/ack data access, timeout abort, MEM/WB register
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              valid_entrada,
  input  logic              wb_reg_write,
  input  logic              wb_mem_to_reg,
  input  logic              m_read,
  input  logic              m_write,
  input  logic [1:0]        m_size,
  input  logic              m_unsigned,
  input  logic [31:0]       resultado,
  input  logic [31:0]       dato_store,
  input  logic [4:0]        reg_destino,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              valid_salida,
  output logic              wb_salida,
  output logic [31:0]       dato_salida,
  output logic [4:0]        reg_destino_salida,
  output logic              excepcion,
  output logic [1:0]        excepcion_causa
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  mem_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q, wb_q, exc_q;
  logic [31:0]      dato_q;
  logic [4:0]       rd_q;
  logic [1:0]       causa_q;

  logic        mem_op, misaligned, access, timeout, done_ok, load_sel;
  logic [31:0] load_data, dato_d;

  mem_align u_align (
    .size_i       (m_size),
    .unsigned_i   (m_unsigned),
    .addr_lo_i    (resultado[1:0]),
    .store_data_i (dato_store),
    .rdata_i      (mem_rdata),
    .be_o         (mem_be),
    .wdata_o      (mem_wdata),
    .load_data_o  (load_data)
  );

  always_comb begin
    mem_op     = valid_entrada & (m_read | m_write);
    misaligned = mem_op & is_misaligned(m_size, resultado[1:0]);
    access     = mem_op & ~misaligned;
    // Ack in the final allowed cycle still completes the access.
    timeout    = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) && !mem_ack;
    done_ok    = access & mem_ack;
    load_sel   = m_read | (wb_mem_to_reg & ~m_write);
    dato_d     = (done_ok && load_sel) ? load_data : resultado;
    mem_req    = reset_n & access;
    stall      = reset_n & access & ~mem_ack & ~timeout;
    mem_we     = m_write;
    mem_addr   = {resultado[ADDR_W-1:2], 2'b00};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wb_q    <= 1'b0;
      exc_q   <= 1'b0;
      causa_q <= CAUSE_NONE;
      dato_q  <= '0;
      rd_q    <= '0;
    end else if (stall) begin
      // Counter reads 0 during the request cycle in IDLE, so WAIT starts at 1.
      state_q <= ST_WAIT;
      cnt_q   <= (state_q == ST_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
      valid_q <= 1'b0;
      wb_q    <= 1'b0;
      exc_q   <= 1'b0;
      causa_q <= CAUSE_NONE;
    end else begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= valid_entrada;
      wb_q    <= valid_entrada & wb_reg_write & ~misaligned & ~timeout;
      exc_q   <= misaligned | timeout;
      causa_q <= misaligned ? CAUSE_MISALIGN : (timeout ? CAUSE_TIMEOUT : CAUSE_NONE);
      dato_q  <= dato_d;
      rd_q    <= reg_destino;
    end
  end

  assign valid_salida       = valid_q;
  assign wb_salida          = wb_q;
  assign dato_salida        = dato_q;
  assign reg_destino_salida = rd_q;
  assign excepcion          = exc_q;
  assign excepcion_causa    = causa_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized self-checking bench for mem_access_stage
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        valid_entrada, wb_reg_write, wb_mem_to_reg, m_read, m_write, m_unsigned;
  logic [1:0]  m_size;
  logic [31:0] resultado, dato_store, mem_rdata;
  logic [4:0]  reg_destino;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        valid_salida, wb_salida, excepcion;
  logic [31:0] dato_salida;
  logic [4:0]  reg_destino_salida;
  logic [1:0]  excepcion_causa;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mem_access_stage #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset_n(reset_n), .valid_entrada(valid_entrada),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .m_read(m_read),
    .m_write(m_write), .m_size(m_size), .m_unsigned(m_unsigned), .resultado(resultado),
    .dato_store(dato_store), .reg_destino(reg_destino), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .valid_salida(valid_salida),
    .wb_salida(wb_salida), .dato_salida(dato_salida), .reg_destino_salida(reg_destino_salida),
    .excepcion(excepcion), .excepcion_causa(excepcion_causa)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // kind: 0 ALU, 1 load, 2 store. delay >= TO means the ack never arrives in time.
  // Called at posedge+1; returns at posedge+1 after the MEM/WB result is checked.
  task automatic run_instr(input logic v, input int kind, input logic [1:0] size,
                           input logic uns, input logic wbw, input logic [31:0] addr,
                           input logic [31:0] sdata, input logic [4:0] rd,
                           input int delay, input logic [31:0] rdata);
    logic [7:0]  b [4];
    logic [31:0] lv, e_be, e_wd, e_dato;
    int          a, fin;
    bit          mem, mis, acc, timed;
    a     = int'(addr % 4);
    mem   = v && kind != 0;
    mis   = mem && (size == 2'd3 || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a != 0));
    acc   = mem && !mis;
    timed = acc && delay >= TO;
    fin   = !acc ? 0 : (delay < TO ? delay : TO - 1);
    for (int i = 0; i < 4; i++) b[i] = 8'(rdata >> (8 * i));
    if (size == 2'd0) begin
      lv = 32'(b[a]);
      if (!uns && lv >= 128) lv = lv + 32'hFFFF_FF00;
      e_be = 32'(1) << a;
      e_wd = (sdata % 256) * 32'h0101_0101;
    end else if (size == 2'd1) begin
      lv = 32'(b[a]) + 256 * 32'(b[(a + 1) % 4]);
      if (!uns && lv >= 32768) lv = lv + 32'hFFFF_0000;
      e_be = 32'(3) << a;
      e_wd = (sdata % 65536) * 32'h0001_0001;
    end else begin
      lv   = rdata;
      e_be = 32'd15;
      e_wd = sdata;
    end
    e_dato = (kind == 1) ? lv : addr;

    valid_entrada = v;
    wb_reg_write  = wbw;
    wb_mem_to_reg = (kind == 1);
    m_read        = (kind == 1);
    m_write       = (kind == 2);
    m_size        = size;
    m_unsigned    = uns;
    resultado     = addr;
    dato_store    = sdata;
    reg_destino   = rd;
    for (int k = 0; k <= fin; k++) begin
      mem_ack   = acc && (k == delay);
      mem_rdata = mem_ack ? rdata : $urandom;
      @(negedge clock);
      check_val("stall", 32'(stall), 32'(k < fin));
      check_val("mem_req", 32'(mem_req), 32'(acc));
      if (acc) begin
        check_val("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check_val("mem_be", 32'(mem_be), e_be);
        check_val("mem_we", 32'(mem_we), 32'(kind == 2));
        if (kind == 2) check_val("mem_wdata", mem_wdata, e_wd);
      end
      @(posedge clock);
      #1;
    end
    mem_ack = 1'b0;
    check_val("valid_salida", 32'(valid_salida), 32'(v));
    check_val("wb_salida", 32'(wb_salida), 32'(v && !mis && !timed && wbw));
    check_val("excepcion", 32'(excepcion), 32'(mis || timed));
    check_val("causa", 32'(excepcion_causa), mis ? 32'd1 : (timed ? 32'd2 : 32'd0));
    if (v && !mis && !timed) begin
      check_val("dato_salida", dato_salida, e_dato);
      check_val("rd_salida", 32'(reg_destino_salida), 32'(rd));
    end
  endtask

  initial begin
    int r, kind, dly;
    logic [1:0] sz;
    reset_n = 1'b0;
    valid_entrada = 1'b1; wb_reg_write = 1'b1; wb_mem_to_reg = 1'b1;
    m_read = 1'b1; m_write = 1'b0; m_size = 2'd2; m_unsigned = 1'b0;
    resultado = 32'h100; dato_store = '0; reg_destino = 5'd1;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_mem_req", 32'(mem_req), 32'd0);
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_valid", 32'(valid_salida), 32'd0);
    check_val("rst_dato", dato_salida, 32'd0);
    check_val("rst_exc", 32'(excepcion), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    run_instr(1, 0, 2'd2, 0, 1, 32'h0000_1234, 0, 5'd5, 0, 0);          // ALU op
    run_instr(1, 1, 2'd0, 0, 1, 32'h103, 0, 5'd6, 3, 32'h8012_3456);    // lb, 3 waits
    run_instr(1, 1, 2'd0, 1, 1, 32'h103, 0, 5'd7, 3, 32'h8012_3456);    // lbu
    run_instr(1, 2, 2'd1, 0, 0, 32'h102, 32'h0000_BEEF, 5'd0, 0, 0);    // sh zero-wait
    run_instr(1, 1, 2'd2, 0, 1, 32'h101, 0, 5'd8, 0, 0);                // lw misaligned
    run_instr(1, 1, 2'd2, 0, 1, 32'h200, 0, 5'd9, 100, 0);              // lw timeout
    run_instr(0, 0, 2'd0, 0, 0, 32'h0, 0, 5'd0, 0, 0);                  // bubble after abort
    run_instr(1, 1, 2'd2, 0, 1, 32'h204, 0, 5'd10, TO - 1, 32'hCAFE_F00D); // ack on last cycle
    run_instr(1, 1, 2'd3, 0, 1, 32'h208, 0, 5'd11, 0, 0);               // reserved size
    run_instr(1, 1, 2'd1, 0, 1, 32'h20A, 0, 5'd12, 1, 32'h9234_5678);   // lh upper half

    // Reset while waiting: outputs clear at once, a late ack does nothing.
    run_instr(1, 0, 2'd2, 0, 1, 32'h5A5A_0001, 0, 5'd13, 0, 0);
    valid_entrada = 1'b1; m_read = 1'b1; m_write = 1'b0; wb_mem_to_reg = 1'b1;
    m_size = 2'd2; resultado = 32'h300; reg_destino = 5'd14;
    repeat (3) @(posedge clock);
    #2;
    check_val("wait_stall", 32'(stall), 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("arst_mem_req", 32'(mem_req), 32'd0);
    check_val("arst_dato", dato_salida, 32'd0);
    check_val("arst_rd", 32'(reg_destino_salida), 32'd0);
    check_val("arst_valid", 32'(valid_salida), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    valid_entrada = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    check_val("late_ack_req", 32'(mem_req), 32'd0);
    @(posedge clock);
    #1;
    mem_ack = 1'b0;
    check_val("late_ack_valid", 32'(valid_salida), 32'd0);
    check_val("late_ack_wb", 32'(wb_salida), 32'd0);
    check_val("late_ack_exc", 32'(excepcion), 32'd0);

    for (int i = 0; i < 200; i++) begin
      r    = $urandom_range(0, 9);
      sz   = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      kind = $urandom_range(0, 2);
      r    = $urandom_range(0, 19);
      dly  = (r < 6) ? 0 : (r < 17) ? $urandom_range(1, 6) : TO + $urandom_range(0, 4);
      run_instr($urandom_range(0, 9) != 0, kind, sz, 1'($urandom), 1'($urandom),
                $urandom, $urandom, 5'($urandom), dly, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
